// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and width limits.
package serial_adder_pkg;

  localparam int SA_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Existing 1-bit full adder cell used as the single bit-slice of serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first, one full_adder cell plus a carry flop.
// Optional signed-overflow output OVF when SERIAL_ADDER_OVF_EN is defined.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > SA_MAX_WIDTH) begin : g_bad_width
    $error("serial_adder: WIDTH out of range 2..SA_MAX_WIDTH");
  end

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s, c;
  logic             accept, last;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (s),
    .co (c)
  );

  assign accept  = START && (state_q == S_IDLE || state_q == S_DONE);
  assign last    = (state_q == S_RUN) && (cnt == CW'(WIDTH - 1));
  assign res_nxt = {s, res_sr[WIDTH-1:1]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = START ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // BUSY/DONE are flopped copies of the next state so outputs stay registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      SUM    <= '0;
      COUT   <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      OVF    <= 1'b0;
`endif
    end else begin
      BUSY <= (state_d == S_RUN);
      DONE <= (state_d == S_DONE);
      if (accept) begin
        a_sr   <= A;
        b_sr   <= B;
        carry  <= CIN;
        cnt    <= '0;
        res_sr <= '0;
      end else if (state_q == S_RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= res_nxt;
        carry  <= c;
        cnt    <= cnt + CW'(1);
        if (last) begin
          SUM  <= res_nxt;
          COUT <= c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry still holds the carry into the MSB on the last bit
          OVF  <= carry ^ c;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8); checks OVF too when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         CIN = 1'b0;
  logic         BUSY, DONE, COUT;
  logic [W-1:0] SUM;
`ifdef SERIAL_ADDER_OVF_EN
  logic         OVF;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .CIN(CIN),
    .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT)
`ifdef SERIAL_ADDER_OVF_EN
    , .OVF(OVF)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected result on every DONE pulse.
  always @(negedge CLK) begin
    if (!RST) begin
      chk("busy_done_exclusive", {31'd0, BUSY & DONE}, 32'd0);
      if (DONE) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got DONE=1 expected no pending result at %0t", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", {24'd0, SUM}, {24'd0, e.s});
          chk("cout", {31'd0, COUT}, {31'd0, e.c});
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf", {31'd0, OVF}, {31'd0, e.o});
`endif
        end
      end
    end
  end

  task automatic push(input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    e.s = s; e.c = c; e.o = o;
    q.push_back(e);
  endtask

  // One addition with cycle-exact BUSY/DONE timing checks.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    @(negedge CLK);
    START = 1'b1; A = a; B = b; CIN = ci;
    push(es, ec, eo);
    @(posedge CLK); #1;
    START = 1'b0;
    chk("busy_after_accept", {31'd0, BUSY}, 32'd1);
    for (int i = 1; i <= W; i++) begin
      @(posedge CLK); #1;
      chk("busy_timing", {31'd0, BUSY}, {31'd0, (i < W)});
      chk("done_timing", {31'd0, DONE}, {31'd0, (i == W)});
    end
    @(posedge CLK); #1;
    chk("done_one_cycle", {31'd0, DONE}, 32'd0);
  endtask

  initial begin
    #12;
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    chk("reset_done", {31'd0, DONE}, 32'd0);
    chk("reset_sum", {24'd0, SUM}, 32'd0);
    chk("reset_cout", {31'd0, COUT}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    do_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // START during RUN must be ignored
    @(negedge CLK);
    START = 1'b1; A = 8'h10; B = 8'h20; CIN = 1'b0;
    push(8'h30, 1'b0, 1'b0);
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    START = 1'b1; A = 8'hFF; B = 8'hFF;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("ignore_done_at_8", {31'd0, DONE}, 32'd1);
    @(posedge CLK); #1;
    chk("ignore_done_cleared", {31'd0, DONE}, 32'd0);

    // Reset mid-run: async clear, no DONE
    @(negedge CLK);
    START = 1'b1; A = 8'h33; B = 8'h44;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_sum", {24'd0, SUM}, 32'd0);
    chk("rst_cout", {31'd0, COUT}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (12) @(posedge CLK);
    do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // START held high: one result every W+1 cycles
    push(8'h03, 1'b0, 1'b0);
    push(8'h03, 1'b0, 1'b0);
    push(8'h03, 1'b0, 1'b0);
    @(negedge CLK);
    START = 1'b1; A = 8'h01; B = 8'h02; CIN = 1'b0;
    @(posedge CLK);
    for (int k = 1; k <= 26; k++) begin
      @(posedge CLK); #1;
      chk("b2b_done", {31'd0, DONE}, {31'd0, (k == 8 || k == 17 || k == 26)});
      if (k == 26) START = 1'b0;
    end
    repeat (12) @(posedge CLK);
    #1;
    chk("b2b_idle", {31'd0, BUSY}, 32'd0);
    chk("scoreboard_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
